spi_multi_engine: RTL

- Parametrised successor to the single-device SPI controller: one shift engine shared across CHANNELS chip-select channels.
- Double-banked TX/RX byte buffers of BUF_DEPTH bytes per bank.
- Transfer modes: write, read, exchange, wait-and-read; wait-and-read gains a byte timeout.
- Sits between the cartridge register/bus decode (FastClk domain) and the external SPI devices (flash, TF card, extra peripherals).

---
 rtl/spi_multi_engine.sv | 293 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_multi_engine.sv
// spi_multi_engine
//   One SPI mode-0 (MSB first) shift engine shared by CHANNELS device channels.
//   It has double-banked TX/RX byte buffers of BUF_DEPTH bytes per bank.
//   The CPU writes TX bytes into bank CpuBank and reads RX data from it
//   as 16-bit little-endian byte pairs. The engine works on bank
//   EngineBank, which is latched when a transfer starts.
//
// Transfer modes:
//   0 write          : send the buffer bytes; nothing is stored
//   1 read           : send 0xFF and store every received byte
//   2 exchange       : send the buffer bytes and store every received byte
//   3 wait-and-read  : send 0xFF. Leading 0xFF bytes are dropped until the
//                      first other byte arrives. After WAIT_TIMEOUT dropped
//                      bytes the transfer aborts and sets Timeout.
//
// Ports:
//   FastClk, Reset              clock, synchronous active-high reset
//   Start/Mode/Len/Channel/
//   EngineBank/Div              transfer request, latched on Start while idle
//   CsWrEn/CsWrData             chip-select register write (1 = asserted)
//   CpuBank/TxWr*/RxRd*         CPU buffer ports; RxRdData has 1 cycle latency
//   Busy, Timeout               engine status
//   SpiClk/SpiDo/SpiDi/SpiCs_n  per-channel SPI pins
module spi_multi_engine #(
  parameter int CHANNELS     = 2,
  parameter int BUF_DEPTH    = 512,
  parameter int DIV_WIDTH    = 8,
  parameter int WAIT_TIMEOUT = 256,
  localparam int AW = $clog2(BUF_DEPTH),
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int WW = $clog2(WAIT_TIMEOUT + 1)
) (
  input  logic                 FastClk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [1:0]           Mode,
  input  logic [AW-1:0]        Len,
  input  logic [CW-1:0]        Channel,
  input  logic                 EngineBank,
  input  logic [DIV_WIDTH-1:0] Div,
  input  logic                 CsWrEn,
  input  logic [CHANNELS-1:0]  CsWrData,
  input  logic                 CpuBank,
  input  logic                 TxWrEn,
  input  logic [AW-1:0]        TxWrAddr,
  input  logic [7:0]           TxWrData,
  input  logic [AW-1:0]        RxRdAddr,
  output logic [15:0]          RxRdData,
  output logic                 Busy,
  output logic                 Timeout,
  output logic [CHANNELS-1:0]  SpiClk,
  output logic [CHANNELS-1:0]  SpiDo,
  input  logic [CHANNELS-1:0]  SpiDi,
  output logic [CHANNELS-1:0]  SpiCs_n
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_STORE
  } state_t;

  state_t               state_reg;
  logic [1:0]           mode_reg;
  logic [AW-1:0]        len_reg;
  logic [CW-1:0]        chan_reg;
  logic                 bank_reg;
  logic [DIV_WIDTH-1:0] div_reg;
  logic [DIV_WIDTH-1:0] div_cnt_reg;
  logic [AW-1:0]        idx_reg;
  logic [2:0]           bit_cnt_reg;
  logic [WW-1:0]        wait_cnt_reg;
  logic                 data_phase_reg;
  logic                 load_ready_reg;
  logic                 sck_reg;
  logic [7:0]           tx_shift_reg;
  logic [7:0]           rx_shift_reg;
  logic                 busy_reg;
  logic                 timeout_reg;
  logic [CHANNELS-1:0]  cs_reg;
  logic [7:0]           tx_rd_reg;

  logic                 miso;
  logic [7:0]           load_byte;
  logic                 rx_keep;
  logic                 rx_we;
  logic [AW-1:0]        rx_wr_word;
  logic [AW-1:0]        rx_rd_word;
  logic                 unused_addr_lsb;

  // ---------------------------------------------------------------------------
  // TX buffer: both banks live in one array addressed by {bank, byte}.
  // The CPU writes and the engine reads through a registered port.
  // ---------------------------------------------------------------------------
  logic [7:0] tx_mem [2*BUF_DEPTH];

  always_ff @(posedge FastClk) begin
    if (TxWrEn) begin
      tx_mem[{CpuBank, TxWrAddr}] <= TxWrData;
    end
    tx_rd_reg <= tx_mem[{bank_reg, idx_reg}];
  end

  // ---------------------------------------------------------------------------
  // RX buffer: split into even and odd byte lanes. This lets the CPU read a
  // 16-bit pair in one access while the engine writes single bytes.
  // Word address = {bank, byte index without bit 0}.
  // ---------------------------------------------------------------------------
  assign rx_wr_word      = {bank_reg, idx_reg[AW-1:1]};
  assign rx_rd_word      = {CpuBank, RxRdAddr[AW-1:1]};
  assign unused_addr_lsb = RxRdAddr[0];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rx_lane
      logic [7:0] mem [BUF_DEPTH];
      logic [7:0] rd_reg;

      always_ff @(posedge FastClk) begin
        if (rx_we && (idx_reg[0] == 1'(gi))) begin
          mem[rx_wr_word] <= rx_shift_reg;
        end
      end

      always_ff @(posedge FastClk) begin
        if (Reset) begin
          rd_reg <= 8'h00;
        end else begin
          rd_reg <= mem[rx_rd_word];
        end
      end
    end
  endgenerate

  assign RxRdData = {g_rx_lane[1].rd_reg, g_rx_lane[0].rd_reg};

  // ---------------------------------------------------------------------------
  // Chip-select register. The engine never changes it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge FastClk) begin
    if (Reset) begin
      cs_reg <= '0;
    end else if (CsWrEn) begin
      cs_reg <= CsWrData;
    end
  end

  assign SpiCs_n = ~cs_reg;

  // ---------------------------------------------------------------------------
  // Pin fan-out. When idle, sck_reg is 0 and tx_shift_reg is 0xFF, so every
  // channel rests at SCK=0 / MOSI=1. Only the latched channel sees activity.
  // ---------------------------------------------------------------------------
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_pins
      assign SpiClk[gi] = sck_reg & (chan_reg == CW'(gi));
      assign SpiDo[gi]  = (chan_reg == CW'(gi)) ? tx_shift_reg[7] : 1'b1;
    end
  endgenerate

  assign miso = SpiDi[chan_reg];

  // Modes 0 and 2 (bit 0 clear) send buffer data; the other modes send 0xFF.
  assign load_byte = mode_reg[0] ? 8'hFF : tx_rd_reg;

  // Decide whether the byte that has just finished is kept in the RX buffer.
  always_comb begin
    rx_keep = 1'b0;
    case (mode_reg)
      2'd1, 2'd2: rx_keep = 1'b1;
      2'd3:       rx_keep = data_phase_reg || (rx_shift_reg != 8'hFF);
      default:    rx_keep = 1'b0;
    endcase
  end

  assign rx_we = (state_reg == S_STORE) && rx_keep;

  // ---------------------------------------------------------------------------
  // Transfer state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge FastClk) begin
    if (Reset) begin
      state_reg      <= S_IDLE;
      mode_reg       <= 2'd0;
      len_reg        <= '0;
      chan_reg       <= '0;
      bank_reg       <= 1'b0;
      div_reg        <= '0;
      div_cnt_reg    <= '0;
      idx_reg        <= '0;
      bit_cnt_reg    <= 3'd0;
      wait_cnt_reg   <= '0;
      data_phase_reg <= 1'b0;
      load_ready_reg <= 1'b0;
      sck_reg        <= 1'b0;
      tx_shift_reg   <= 8'hFF;
      rx_shift_reg   <= 8'h00;
      busy_reg       <= 1'b0;
      timeout_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (Start) begin
            mode_reg       <= Mode;
            len_reg        <= Len;
            chan_reg       <= Channel;
            bank_reg       <= EngineBank;
            div_reg        <= Div;
            idx_reg        <= '0;
            wait_cnt_reg   <= '0;
            data_phase_reg <= 1'b0;
            load_ready_reg <= 1'b0;
            timeout_reg    <= 1'b0;
            busy_reg       <= 1'b1;
            state_reg      <= S_LOAD;
          end
        end

        // The first cycle lets the TX read register catch up with the new
        // index. The second cycle loads the shifter and presents the MSB.
        S_LOAD: begin
          if (!load_ready_reg) begin
            load_ready_reg <= 1'b1;
          end else begin
            load_ready_reg <= 1'b0;
            tx_shift_reg   <= load_byte;
            bit_cnt_reg    <= 3'd0;
            div_cnt_reg    <= '0;
            sck_reg        <= 1'b0;
            state_reg      <= S_SHIFT;
          end
        end

        // Each SCK half lasts div_reg+1 cycles. The pin changes at the end of
        // a half. MISO is captured as SCK rises. The next MOSI bit goes out as
        // SCK falls, except after the eighth bit.
        S_SHIFT: begin
          if (div_cnt_reg == div_reg) begin
            div_cnt_reg <= '0;
            if (!sck_reg) begin
              sck_reg      <= 1'b1;
              rx_shift_reg <= {rx_shift_reg[6:0], miso};
            end else begin
              sck_reg <= 1'b0;
              if (bit_cnt_reg == 3'd7) begin
                state_reg <= S_STORE;
              end else begin
                bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                tx_shift_reg <= {tx_shift_reg[6:0], 1'b1};
              end
            end
          end else begin
            div_cnt_reg <= div_cnt_reg + DIV_WIDTH'(1);
          end
        end

        S_STORE: begin
          if ((mode_reg == 2'd3) && !rx_keep) begin
            // Leading 0xFF in wait-and-read: drop it and keep the same index.
            if (wait_cnt_reg == WW'(WAIT_TIMEOUT - 1)) begin
              timeout_reg  <= 1'b1;
              busy_reg     <= 1'b0;
              tx_shift_reg <= 8'hFF;
              state_reg    <= S_IDLE;
            end else begin
              wait_cnt_reg <= wait_cnt_reg + WW'(1);
              state_reg    <= S_LOAD;
            end
          end else begin
            if (mode_reg == 2'd3) begin
              data_phase_reg <= 1'b1;
            end
            if (idx_reg == len_reg) begin
              busy_reg     <= 1'b0;
              tx_shift_reg <= 8'hFF;
              state_reg    <= S_IDLE;
            end else begin
              idx_reg   <= idx_reg + AW'(1);
              state_reg <= S_LOAD;
            end
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign Busy    = busy_reg;
  assign Timeout = timeout_reg;

endmodule
